// File: rtl/edge_frame_writer_pkg.sv
// edge_frame_writer_pkg
//   Shared constants for the edge frame writer slice: the default frame
//   geometry, the memory address width, the FIFO entry layout, and the
//   binarisation helper used by the capture stage.
package edge_frame_writer_pkg;

  localparam int unsigned PIX_W           = 8;
  localparam int unsigned FRAME_W         = 220;
  localparam int unsigned FRAME_H         = 220;
  // The 3x1 vertical kernel drops the top and bottom rows.
  localparam int unsigned FRAME_NPIX      = FRAME_W * (FRAME_H - 2);
  localparam int unsigned MEM_ADDR_W      = 16;
  // The first output pixel sits on row 1, the kernel centre row.
  localparam int unsigned FRAME_ADDR_BASE = FRAME_W;
  // FIFO entry = {addr, data}.
  localparam int unsigned ENTRY_W         = MEM_ADDR_W + PIX_W;

  localparam logic [PIX_W-1:0] PIX_ON  = 8'hFF;
  localparam logic [PIX_W-1:0] PIX_OFF = 8'h00;

  // Pixels at or above the threshold count as edges.
  function automatic logic [PIX_W-1:0] binarise(input logic [PIX_W-1:0] pxl,
                                                input logic [PIX_W-1:0] thresh);
    return (pxl >= thresh) ? PIX_ON : PIX_OFF;
  endfunction

endpackage

// File: rtl/edge_frame_writer_fifo.sv
// edge_fifo
//   Synchronous FIFO with a first-word-fall-through head. A push into a
//   full FIFO is honoured only when a pop happens in the same cycle.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     push, push_data   write request and entry
//     pop               read request (ignored when empty)
//     head              oldest entry, valid while !empty
//     full, empty       occupancy flags
//     level             current number of entries
module edge_fifo
  import edge_frame_writer_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned WIDTH = ENTRY_W,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot this push needs, so full+push+pop is legal.
  assign do_push = push && (!full || do_pop);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // flops sample their inputs from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and level alone
  // define which entries are meaningful, so clearing data buys nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/edge_frame_writer.sv
// edge_frame_writer
//   Sink for the vertical gradient stream. Each valid pixel is optionally
//   binarised, tagged with its frame-buffer address, registered, and pushed
//   into a small FIFO that drains to a single-port memory via mem_we /
//   mem_ready. The upstream has no backpressure, so a push into a full FIFO
//   drops the pixel and sets a sticky overflow flag.
//   Ports:
//     clk, reset        clock, asynchronous active-low reset
//     pxl_in, valid     gradient pixel stream
//     thresh_en         1: binarise against THRESH, 0: pass through
//     mem_addr/mem_data FIFO head (0 while the FIFO is empty)
//     mem_we, mem_ready write request / memory accept
//     fifo_level        FIFO occupancy
//     overflow          sticky: a pixel was dropped
//     frame_done        one-cycle pulse when the last pixel of a frame is
//                       written (or the cycle after it was dropped)
module edge_frame_writer
  import edge_frame_writer_pkg::*;
#(
  parameter  int unsigned W          = FRAME_W,
  parameter  int unsigned H          = FRAME_H,
  parameter  int unsigned THRESH     = 40,
  parameter  int unsigned FIFO_DEPTH = 8,
  parameter  int unsigned ADDR_W     = MEM_ADDR_W,
  parameter  int unsigned ADDR_BASE  = W,
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        pxl_in,
  input  logic              valid,
  input  logic              thresh_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow,
  output logic              frame_done
);

  localparam int unsigned       NPIX       = W * (H - 2);
  localparam int unsigned       EW         = ADDR_W + PIX_W;
  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(ADDR_BASE);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(ADDR_BASE + NPIX - 1);
  localparam logic [PIX_W-1:0]  THRESH_V   = PIX_W'(THRESH);

  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic              cap_valid_q, cap_valid_d;
  logic [PIX_W-1:0]  cap_data_q, cap_data_d;
  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic              overflow_q, overflow_d;
  logic              drop_last_q, drop_last_d;

  logic [EW-1:0]     fifo_head;
  logic              fifo_full, fifo_empty;
  logic              pop_fire, push_drop;

  assign mem_we    = !fifo_empty;
  assign pop_fire  = mem_we && mem_ready;
  assign push_drop = cap_valid_q && fifo_full && !pop_fire;

  always_comb begin
    addr_cnt_d  = addr_cnt_q;
    cap_valid_d = valid;
    cap_data_d  = cap_data_q;
    cap_addr_d  = cap_addr_q;
    if (valid) begin
      cap_data_d = thresh_en ? binarise(pxl_in, THRESH_V) : pxl_in;
      cap_addr_d = addr_cnt_q;
      // Advances even for pixels that will be dropped, so later pixels
      // keep their true frame position.
      addr_cnt_d = (addr_cnt_q == ADDR_LAST) ? ADDR_FIRST : addr_cnt_q + 1'b1;
    end
    overflow_d  = overflow_q || push_drop;
    // A dropped last pixel never reaches the memory; flag the frame end
    // one cycle later instead.
    drop_last_d = push_drop && (cap_addr_q == ADDR_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_cnt_q  <= ADDR_FIRST;
      cap_valid_q <= 1'b0;
      cap_data_q  <= '0;
      cap_addr_q  <= '0;
      overflow_q  <= 1'b0;
      drop_last_q <= 1'b0;
    end else begin
      addr_cnt_q  <= addr_cnt_d;
      cap_valid_q <= cap_valid_d;
      cap_data_q  <= cap_data_d;
      cap_addr_q  <= cap_addr_d;
      overflow_q  <= overflow_d;
      drop_last_q <= drop_last_d;
    end
  end

  edge_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (cap_valid_q),
    .push_data ({cap_addr_q, cap_data_q}),
    .pop       (pop_fire),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // The storage array is not reset, so the head is masked while empty.
  assign mem_addr   = fifo_empty ? '0 : fifo_head[EW-1:PIX_W];
  assign mem_data   = fifo_empty ? '0 : fifo_head[PIX_W-1:0];
  assign overflow   = overflow_q;
  assign frame_done = (pop_fire && (mem_addr == ADDR_LAST)) || drop_last_q;

endmodule

// File: tb/tb_edge_frame_writer.sv
// tb_edge_frame_writer
//   Scoreboard bench: each accepted pixel's expected {addr, data} is queued
//   when it is driven and compared when the memory handshake occurs. A
//   second instance with a 4x4 frame exercises address wrap / frame_done.
`timescale 1ns/1ps
module tb_edge_frame_writer;
  import edge_frame_writer_pkg::*;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Default-geometry instance (220x220, base 220).
  logic [7:0]  pxl_in    = '0;
  logic        valid     = 1'b0;
  logic        thresh_en = 1'b0;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic        frame_done;

  // Small-frame instance (4x4, NPIX=8, base 4).
  logic [7:0]  f_pxl_in    = '0;
  logic        f_valid     = 1'b0;
  logic        f_thresh_en = 1'b0;
  logic        f_mem_ready = 1'b0;
  logic [15:0] f_mem_addr;
  logic [7:0]  f_mem_data;
  logic        f_mem_we;
  logic [3:0]  f_fifo_level;
  logic        f_overflow;
  logic        f_frame_done;

  edge_frame_writer dut (
    .clk        (clk),
    .reset      (reset),
    .pxl_in     (pxl_in),
    .valid      (valid),
    .thresh_en  (thresh_en),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .frame_done (frame_done)
  );

  edge_frame_writer #(.W(4), .H(4)) dut_f (
    .clk        (clk),
    .reset      (reset),
    .pxl_in     (f_pxl_in),
    .valid      (f_valid),
    .thresh_en  (f_thresh_en),
    .mem_addr   (f_mem_addr),
    .mem_data   (f_mem_data),
    .mem_we     (f_mem_we),
    .mem_ready  (f_mem_ready),
    .fifo_level (f_fifo_level),
    .overflow   (f_overflow),
    .frame_done (f_frame_done)
  );

  wr_t exp_q[$];
  int  next_addr;
  int  checks = 0;
  int  passed = 0;

  // Reference model for the default instance: expected write for a pixel.
  task automatic model_pixel(input logic [7:0] p, input logic ten, input bit kept);
    wr_t e;
    e.addr = 16'(next_addr);
    e.data = ten ? ((p >= 8'd40) ? 8'hFF : 8'h00) : p;
    if (kept) exp_q.push_back(e);
    next_addr = (next_addr == int'(FRAME_ADDR_BASE + FRAME_NPIX) - 1)
                ? int'(FRAME_ADDR_BASE) : next_addr + 1;
  endtask

  task automatic do_reset;
    valid = 1'b0; f_valid = 1'b0; mem_ready = 1'b0; f_mem_ready = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    next_addr = 220;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valid  = i[0];
      pxl_in = 8'(i * 50);
      @(negedge clk);
      checks++;
      if ({mem_we, fifo_level, overflow, frame_done} !== 7'b0)
        $display("FAIL reset_hold cyc%0d: we=%b lvl=%0d ovf=%b fd=%b, want all 0",
                 i, mem_we, fifo_level, overflow, frame_done);
      else passed++;
    end
    valid = 1'b0;
    reset = 1'b1;
    next_addr = 220;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_we, fifo_level, overflow, frame_done, mem_addr, mem_data} !== 31'b0)
        $display("FAIL reset_idle cyc%0d: we=%b lvl=%0d ovf=%b fd=%b addr=%0d data=%h, want all 0",
                 i, mem_we, fifo_level, overflow, frame_done, mem_addr, mem_data);
      else passed++;
    end
  endtask

  task automatic test_threshold;
    logic [7:0] pix [4];
    wr_t e;
    pix[0] = 8'd41; pix[1] = 8'd40; pix[2] = 8'd39; pix[3] = 8'h5A;
    do_reset();
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pxl_in    = pix[k];
      thresh_en = (k < 3);
      valid     = 1'b1;
      model_pixel(pix[k], thresh_en, 1'b1);
      @(negedge clk);
      valid = 1'b0;
      checks++;
      if (mem_we !== 1'b0) $display("FAIL thr_latency px%0d: mem_we=%b one cycle after valid, want 0", k, mem_we);
      else passed++;
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1) $display("FAIL thr_we px%0d: mem_we=%b two cycles after valid, want 1", k, mem_we);
      else passed++;
      e = exp_q.pop_front();
      checks++;
      if ({mem_addr, mem_data} !== {e.addr, e.data})
        $display("FAIL thr_write px%0d: addr=%0d data=%h, want addr=%0d data=%h",
                 k, mem_addr, mem_data, e.addr, e.data);
      else passed++;
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0) $display("FAIL thr_drained px%0d: mem_we=%b, want 0", k, mem_we);
      else passed++;
    end
  endtask

  task automatic test_backpressure;
    wr_t e;
    do_reset();
    thresh_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pxl_in = 8'(8'h10 + i);
      valid  = 1'b1;
      model_pixel(pxl_in, 1'b0, i < 8);
      @(negedge clk);
      if (i == 8) begin
        checks++;
        if ({fifo_level, overflow} !== {4'd8, 1'b0})
          $display("FAIL bp_full: lvl=%0d ovf=%b, want lvl=8 ovf=0", fifo_level, overflow);
        else passed++;
      end
      if (i == 9) begin
        checks++;
        if (overflow !== 1'b1) $display("FAIL bp_ovf: ovf=%b after 9th push, want 1", overflow);
        else passed++;
      end
    end
    valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({fifo_level, overflow} !== {4'd8, 1'b1})
      $display("FAIL bp_hold: lvl=%0d ovf=%b, want lvl=8 ovf=1", fifo_level, overflow);
    else passed++;
    mem_ready = 1'b1;
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      if (mem_we) begin
        e = exp_q.pop_front();
        checks++;
        if ({mem_addr, mem_data} !== {e.addr, e.data})
          $display("FAIL bp_drain: addr=%0d data=%h, want addr=%0d data=%h", mem_addr, mem_data, e.addr, e.data);
        else passed++;
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) $display("FAIL bp_drain_timeout: %0d writes missing, want 0", exp_q.size());
    else passed++;
    checks++;
    if ({mem_we, fifo_level, overflow} !== {1'b0, 4'd0, 1'b1})
      $display("FAIL bp_empty: we=%b lvl=%0d ovf=%b, want we=0 lvl=0 ovf=1", mem_we, fifo_level, overflow);
    else passed++;
    // Two dropped pixels still advanced the address counter.
    pxl_in = 8'hC3; valid = 1'b1;
    model_pixel(pxl_in, 1'b0, 1'b1);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({mem_we, mem_addr, mem_data} !== {1'b1, e.addr, e.data})
      $display("FAIL bp_next: we=%b addr=%0d data=%h, want we=1 addr=%0d data=%h",
               mem_we, mem_addr, mem_data, e.addr, e.data);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_full_pushpop;
    wr_t e;
    do_reset();
    thresh_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      valid  = (i < 9);
      pxl_in = 8'(8'hA0 + i);
      if (i < 9) model_pixel(pxl_in, 1'b0, 1'b1);
      if (i == 9) begin
        // FIFO is full here; pixel 8 is pushed on the same edge as this pop.
        mem_ready = 1'b1;
        e = exp_q.pop_front();
        checks++;
        if ({mem_we, mem_addr, mem_data} !== {1'b1, e.addr, e.data})
          $display("FAIL pp_head: we=%b addr=%0d data=%h, want we=1 addr=%0d data=%h",
                   mem_we, mem_addr, mem_data, e.addr, e.data);
        else passed++;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    mem_ready = 1'b0;
    checks++;
    if ({fifo_level, overflow} !== {4'd8, 1'b0})
      $display("FAIL pp_level: lvl=%0d ovf=%b, want lvl=8 ovf=0", fifo_level, overflow);
    else passed++;
    mem_ready = 1'b1;
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      if (mem_we) begin
        e = exp_q.pop_front();
        checks++;
        if ({mem_addr, mem_data} !== {e.addr, e.data})
          $display("FAIL pp_drain: addr=%0d data=%h, want addr=%0d data=%h", mem_addr, mem_data, e.addr, e.data);
        else passed++;
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) $display("FAIL pp_drain_timeout: %0d writes missing, want 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_frame_wrap;
    int fd_count = 0;
    int fd_good  = 0;
    int got      = 0;
    do_reset();
    f_mem_ready = 1'b1;
    fork
      begin
        wr_t de;
        for (int i = 0; i < 9; i++) begin
          f_pxl_in = 8'(i * 7 + 3);
          f_valid  = 1'b1;
          de.addr  = 16'(4 + (i % 8));
          de.data  = f_pxl_in;
          exp_q.push_back(de);
          @(negedge clk);
        end
        f_valid = 1'b0;
      end
      begin
        wr_t me;
        for (int c = 0; c < 30; c++) begin
          @(negedge clk);
          if (f_frame_done) begin
            fd_count++;
            if (f_mem_we && f_mem_ready && f_mem_addr == 16'd11) fd_good++;
          end
          if (f_mem_we && f_mem_ready && exp_q.size() > 0) begin
            me = exp_q.pop_front();
            got++;
            checks++;
            if ({f_mem_addr, f_mem_data} !== {me.addr, me.data})
              $display("FAIL fw_write%0d: addr=%0d data=%h, want addr=%0d data=%h",
                       got, f_mem_addr, f_mem_data, me.addr, me.data);
            else passed++;
          end
        end
      end
    join
    checks++;
    if (got != 9) $display("FAIL fw_count: %0d writes seen, want 9", got);
    else passed++;
    checks++;
    if (fd_count != 1) $display("FAIL fw_pulses: frame_done pulsed %0d times, want 1", fd_count);
    else passed++;
    checks++;
    if (fd_good != 1) $display("FAIL fw_pulse_slot: %0d pulses on addr 11 handshake, want 1", fd_good);
    else passed++;
  endtask

  task automatic test_mid_reset;
    wr_t e;
    int  fd_count = 0;
    int  got      = 0;
    do_reset();
    thresh_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      pxl_in = 8'(8'h30 + i);
      valid  = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
    @(negedge clk);
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    checks++;
    if ({fifo_level, overflow} !== {4'd5, 1'b1})
      $display("FAIL mr_pre: lvl=%0d ovf=%b, want lvl=5 ovf=1", fifo_level, overflow);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_we, fifo_level, overflow, frame_done} !== 7'b0)
      $display("FAIL mr_cleared: we=%b lvl=%0d ovf=%b fd=%b, want all 0", mem_we, fifo_level, overflow, frame_done);
    else passed++;
    reset = 1'b1;
    exp_q.delete();
    next_addr = 220;
    mem_ready = 1'b1;
    pxl_in = 8'h77; valid = 1'b1;
    model_pixel(pxl_in, 1'b0, 1'b1);
    @(negedge clk);
    valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (frame_done) fd_count++;
      if (mem_we && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got++;
        checks++;
        if ({mem_addr, mem_data} !== {e.addr, e.data})
          $display("FAIL mr_write: addr=%0d data=%h, want addr=%0d data=%h", mem_addr, mem_data, e.addr, e.data);
        else passed++;
      end
      @(negedge clk);
    end
    checks++;
    if (got != 1 || fd_count != 0)
      $display("FAIL mr_after: writes=%0d frame_done=%0d, want writes=1 frame_done=0", got, fd_count);
    else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_threshold();
    test_backpressure();
    test_full_pushpop();
    test_frame_wrap();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/edge_frame_writer.md
Name: edge_frame_writer

Overview:
Downstream sink for the 3x1 vertical gradient stage. Captures the gradient pixel stream (`pxl_in`/`valid`), optionally binarises it against a threshold, and tags each pixel with its frame-buffer address. Pixels are buffered in a small FIFO and drained to a single-port frame memory through a `mem_we`/`mem_ready` handshake. It flags frame completion and input overruns, because the upstream stream has no backpressure.

Parameters:
- W, 220, frame width in pixels
- H, 220, frame height in pixels
- THRESH, 40, binarisation threshold (unsigned 8-bit)
- FIFO_DEPTH, 8, write-buffer entries (power of 2)
- ADDR_W, 16, memory address width (W*H must fit)
- ADDR_BASE, W, address of the first pixel of a frame (row 1, the kernel centre row)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- pxl_in  in  8  gradient magnitude pixel from the convolution stage
- valid  in  1  pxl_in is a valid output pixel this cycle
- thresh_en  in  1  1: binarise the pixel; 0: pass it through
- mem_addr  out  ADDR_W  write address, taken from the FIFO head
- mem_data  out  8  write data, taken from the FIFO head
- mem_we  out  1  write request; high whenever the FIFO is non-empty
- mem_ready  in  1  the memory accepts the write this cycle
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky flag: at least one pixel was dropped
- frame_done  out  1  one-cycle pulse at the end of a frame

Behaviour:
- Reset (reset=0, asynchronous): FIFO emptied; address counter = ADDR_BASE; pixel counter = 0.
  - Outputs: mem_we=0, fifo_level=0, overflow=0, frame_done=0; mem_addr and mem_data = 0.
  - Reset mid-frame discards all buffered pixels. The next accepted pixel is the first pixel of a new frame.
- NPIX = W*(H-2) pixels per frame.
- Capture stage (1 register), active on cycles with valid=1:
  - data_q = thresh_en ? (pxl_in >= THRESH ? 8'hFF : 8'h00) : pxl_in
  - addr_q = current address counter
  - Push into the FIFO on the next cycle.
- Address counter: increments on every valid=1 cycle, including pixels that are dropped, so that later pixels keep their correct addresses.
  - After ADDR_BASE+NPIX-1 it wraps to ADDR_BASE.
  - valid arriving after the wrap starts the next frame.
- Latency: valid at cycle n → push at the n+1 edge → mem_we=1 in cycle n+2 if the FIFO was empty. Throughput is 1 pixel/cycle while mem_ready=1.
- FIFO entry = {addr, data}, ADDR_W+8 bits.
  - Pop on mem_we && mem_ready.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full (the level is unchanged).
  - Push when full with no pop: the pixel is discarded, overflow is set, fifo_level stays at FIFO_DEPTH.
  - overflow clears only on reset.
- mem_addr and mem_data hold steady while mem_we=1 and mem_ready=0.
- frame_done:
  - Pulses in the cycle the write of address ADDR_BASE+NPIX-1 completes its handshake.
  - If that last pixel was dropped, it pulses in the cycle after the drop.
  - Exactly one pulse per frame.

Decomposition:
- Shared package: W, H, NPIX, ADDR_W, ADDR_BASE, and the FIFO entry width constant.
- One sub-module, edge_fifo: synchronous FIFO with parameters DEPTH and WIDTH, outputs full/empty/level, first-word-fall-through head.
- Capture stage, address counter and frame logic stay in edge_frame_writer.

Test Plan:
- Reset: hold reset=0 with valid toggling → mem_we=0, fifo_level=0, overflow=0, frame_done=0 throughout. Release reset → still idle until valid.
- Threshold, thresh_en=1, mem_ready=1, one pixel per test:
  - pxl_in=41 at cycle 0 → mem_we=1 at cycle 2, mem_addr=220, mem_data=8'hFF.
  - pxl_in=40 → 8'hFF.
  - pxl_in=39 → 8'h00.
- Passthrough: thresh_en=0, pxl_in=8'h5A → mem_data=8'h5A.
- Backpressure, mem_ready=0:
  - 10 consecutive valid pixels → fifo_level reaches 8, overflow=1 after the 9th push attempt.
  - Then mem_ready=1 → 8 writes at addresses 220..227.
  - The next new pixel is written at address 230.
- Frame wrap, W=4, H=4 (NPIX=8), mem_ready=1: 9 pixels → writes to addresses 4..11, then 4. frame_done pulses once, in the handshake cycle of address 11.
- Mid-stream reset: reset=0 with fifo_level=5 → FIFO cleared, overflow=0. The next pixel after release is written at ADDR_BASE, and no frame_done pulse occurs.
